// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared state type and default sizing for the SPI pixel master
package spi_master_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} spi_m_state_t;

  localparam int SPI_PIXEL_WIDTH_DEFAULT = 24;
  localparam int SPI_CLK_DIV_DEFAULT     = 4;

endpackage

// File: rtl/spi_half_period_tick.sv
// rtl/spi_half_period_tick.sv - SCK half-period timebase, one-cycle tick every CLK_DIV enabled cycles
module spi_half_period_tick
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic clear_i,
  output logic tick_o
);

  // Guarded so an illegal CLK_DIV still elaborates far enough to report itself.
  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      cnt <= '0;
    end else if (en_i) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CW'(1);
    end
  end

  assign tick_o = en_i && (cnt == LAST);

endmodule

// File: rtl/spi_pixel_master.sv
// rtl/spi_pixel_master.sv - mode-0 SPI initiator moving one pixel word per chip-select frame
module spi_pixel_master
  import spi_master_pkg::*;
#(
  parameter int PIXEL_WIDTH = SPI_PIXEL_WIDTH_DEFAULT,
  parameter int CLK_DIV     = SPI_CLK_DIV_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [PIXEL_WIDTH-1:0] tx_data_i,
  input  logic                   tx_valid_i,
  output logic                   tx_ready_o,
  output logic [PIXEL_WIDTH-1:0] rx_data_o,
  output logic                   rx_valid_o,
  output logic                   busy_o,
  output logic                   spi_sck_o,
  output logic                   spi_cs_o,
  output logic                   spi_sdo_o,
  input  logic                   spi_sdi_i
);

  localparam int W   = PIXEL_WIDTH;
  localparam int HPW = $clog2(2 * W + 1);
  localparam logic [HPW-1:0] LAST_HP = HPW'(2 * W - 1);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_pixel_master: CLK_DIV must be >= 2");
  end

  spi_m_state_t   state, state_d;
  logic [W-1:0]   tx_shift, tx_shift_d;
  logic [W-1:0]   rx_shift, rx_shift_d;
  logic [W-1:0]   rx_data, rx_data_d;
  logic           rx_valid_d;
  logic           sck, sck_d;
  logic           cs, cs_d;
  logic           sdo, sdo_d;
  logic [HPW-1:0] hp_cnt, hp_cnt_d;
  logic           accept;
  logic           tick;

  spi_half_period_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (state != IDLE),
    .clear_i (accept),
    .tick_o  (tick)
  );

  always_comb begin
    state_d    = state;
    tx_shift_d = tx_shift;
    rx_shift_d = rx_shift;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    sck_d      = sck;
    cs_d       = cs;
    sdo_d      = sdo;
    hp_cnt_d   = hp_cnt;
    accept     = 1'b0;

    case (state)
      IDLE: begin
        if (tx_valid_i) begin
          // tx_shift keeps only the bits still to be sent; the MSB goes straight to the pin.
          accept     = 1'b1;
          tx_shift_d = {tx_data_i[W-2:0], 1'b0};
          rx_shift_d = '0;
          sdo_d      = tx_data_i[W-1];
          cs_d       = 1'b0;
          sck_d      = 1'b0;
          hp_cnt_d   = '0;
          state_d    = SETUP;
        end
      end

      SETUP: begin
        if (tick) state_d = SHIFT;
      end

      SHIFT: begin
        if (tick) begin
          sck_d    = ~sck;
          hp_cnt_d = hp_cnt + HPW'(1);
          if (!sck) begin
            rx_shift_d = {rx_shift[W-2:0], spi_sdi_i};
          end else if (hp_cnt == LAST_HP) begin
            state_d = HOLD;
          end else begin
            sdo_d      = tx_shift[W-1];
            tx_shift_d = {tx_shift[W-2:0], 1'b0};
          end
        end
      end

      HOLD: begin
        if (tick) begin
          cs_d       = 1'b1;
          rx_data_d  = rx_shift;
          rx_valid_d = 1'b1;
          state_d    = GAP;
        end
      end

      GAP: begin
        if (tick) begin
          sdo_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      tx_shift   <= '0;
      rx_shift   <= '0;
      rx_data    <= '0;
      rx_valid_o <= 1'b0;
      busy_o     <= 1'b0;
      sck        <= 1'b0;
      cs         <= 1'b1;
      sdo        <= 1'b0;
      hp_cnt     <= '0;
    end else begin
      state      <= state_d;
      tx_shift   <= tx_shift_d;
      rx_shift   <= rx_shift_d;
      rx_data    <= rx_data_d;
      rx_valid_o <= rx_valid_d;
      busy_o     <= (state_d != IDLE);
      sck        <= sck_d;
      cs         <= cs_d;
      sdo        <= sdo_d;
      hp_cnt     <= hp_cnt_d;
    end
  end

  assign tx_ready_o = (state == IDLE);
  assign rx_data_o  = rx_data;
  assign spi_sck_o  = sck;
  assign spi_cs_o   = cs;
  assign spi_sdo_o  = sdo;

endmodule

// File: tb/tb_spi_pixel_master.sv
// tb/tb_spi_pixel_master.sv - directed bench for spi_pixel_master with loopback and slave model
module tb_spi_pixel_master;

  localparam int W = 24;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         busy;
  logic         spi_sck;
  logic         spi_cs;
  logic         spi_sdo;
  logic         spi_sdi;
  logic         loop;
  logic         bfm_sdi;

  assign spi_sdi = loop ? spi_sdo : bfm_sdi;

  spi_pixel_master #(.PIXEL_WIDTH(W), .CLK_DIV(D)) u_dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .busy_o     (busy),
    .spi_sck_o  (spi_sck),
    .spi_cs_o   (spi_cs),
    .spi_sdo_o  (spi_sdo),
    .spi_sdi_i  (spi_sdi)
  );

  logic [7:0] b_tx_data;
  logic       b_tx_valid;
  logic       b_tx_ready;
  logic [7:0] b_rx_data;
  logic       b_rx_valid;
  logic       b_busy;
  logic       b_sck;
  logic       b_cs;
  logic       b_sdo;

  spi_pixel_master #(.PIXEL_WIDTH(8), .CLK_DIV(2)) u_dut_small (
    .clk_i      (clk),
    .reset_i    (reset),
    .tx_data_i  (b_tx_data),
    .tx_valid_i (b_tx_valid),
    .tx_ready_o (b_tx_ready),
    .rx_data_o  (b_rx_data),
    .rx_valid_o (b_rx_valid),
    .busy_o     (b_busy),
    .spi_sck_o  (b_sck),
    .spi_cs_o   (b_cs),
    .spi_sdo_o  (b_sdo),
    .spi_sdi_i  (b_sdo)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int           cyc, rv_n, rises, ready_cyc, busy_low_cyc, cs_first, cs_last;
  int           viol, last_rise, last_sdo_chg, bidx, cs_rise, min_gap;
  int           rv_cyc [4];
  logic [W-1:0] rv_dat [4];
  logic [W-1:0] bfm_rx, bfm_resp;
  logic         prev_sck, prev_cs, prev_sdo;
  int           b_rv_n, b_rv_cyc;
  logic [7:0]   b_rv_dat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; rv_n = 0; rises = 0; ready_cyc = 0; busy_low_cyc = 0;
    cs_first = 0; cs_last = 0; viol = 0; last_rise = 0; last_sdo_chg = 0;
    bidx = 0; cs_rise = 0; min_gap = 0; bfm_rx = '0;
    prev_sck = 1'b0; prev_cs = 1'b1; prev_sdo = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rv_cyc[i] = 0;
      rv_dat[i] = '0;
    end
  endtask

  // Called at a negedge while the master is idle; returns just after the accept edge.
  task automatic start_frame(input logic [W-1:0] data, input logic [W-1:0] resp, input logic hold);
    tx_data  = data;
    tx_valid = 1'b1;
    bfm_resp = resp;
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
    clear_stats();
  endtask

  // Each iteration observes cycle n (outputs settled after the n-1th edge past accept).
  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (rx_valid) begin
        if (rv_n < 4) begin
          rv_cyc[rv_n] = cyc;
          rv_dat[rv_n] = rx_data;
        end
        rv_n++;
      end
      if (!spi_cs) begin
        if (cs_first == 0) cs_first = cyc;
        cs_last = cyc;
      end
      if (tx_ready && ready_cyc == 0) ready_cyc = cyc;
      if (!busy && busy_low_cyc == 0) busy_low_cyc = cyc;
      if (spi_sck && !prev_sck) begin
        rises++;
        bfm_rx = {bfm_rx[W-2:0], spi_sdo};
        if (cyc - last_sdo_chg < D - 1) viol++;
        last_rise = cyc;
      end
      if (spi_sdo !== prev_sdo) begin
        if (last_rise > 0 && cyc - last_rise < D - 1) viol++;
        last_sdo_chg = cyc;
      end
      if (!spi_sck && prev_sck) begin
        bidx++;
        if (bidx < W) bfm_sdi = bfm_resp[W-1-bidx];
      end
      if (!spi_cs && prev_cs) begin
        bidx    = 0;
        bfm_sdi = bfm_resp[W-1];
        if (cs_rise > 0 && (min_gap == 0 || cyc - cs_rise < min_gap)) min_gap = cyc - cs_rise;
      end
      if (spi_cs && !prev_cs) cs_rise = cyc;
      prev_sck = spi_sck;
      prev_cs  = spi_cs;
      prev_sdo = spi_sdo;
    end
  endtask

  initial begin
    reset      = 1'b1;
    tx_data    = '0;
    tx_valid   = 1'b0;
    loop       = 1'b1;
    bfm_sdi    = 1'b0;
    bfm_resp   = '0;
    b_tx_data  = '0;
    b_tx_valid = 1'b0;
    clear_stats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("rst_cs", spi_cs, 1);
    check("rst_sck", spi_sck, 0);
    check("rst_sdo", spi_sdo, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", tx_ready, 1);
    check("rst_small_ready", b_tx_ready, 1);

    // Loopback, single frame
    loop = 1'b1;
    start_frame(24'hA5C30F, 24'h0, 1'b0);
    watch(210);
    check("lb_rv_count", rv_n, 1);
    check("lb_rv_cycle", rv_cyc[0], 201);
    check("lb_rv_data", rv_dat[0], 24'hA5C30F);
    check("lb_sck_rises", rises, 24);
    check("lb_cs_first", cs_first, 1);
    check("lb_cs_last", cs_last, 200);
    check("lb_ready_cycle", ready_cyc, 205);
    check("lb_busy_low", busy_low_cyc, 205);
    check("lb_rx_held", rx_data, 24'hA5C30F);

    // Slave model answers while receiving
    loop = 1'b0;
    start_frame(24'h123456, 24'h0000FF, 1'b0);
    watch(210);
    check("bfm_seen", bfm_rx, 24'h123456);
    check("bfm_rx_data", rv_dat[0], 24'h0000FF);
    check("bfm_rv_cycle", rv_cyc[0], 201);
    check("bfm_mosi_stable", viol, 0);
    check("bfm_sck_rises", rises, 24);

    // Back-to-back with tx_valid held high
    loop = 1'b1;
    start_frame(24'h111111, 24'h0, 1'b1);
    tx_data = 24'h222222;
    watch(206);
    tx_valid = 1'b0;
    watch(204);
    check("b2b_rv_count", rv_n, 2);
    check("b2b_rv_cyc0", rv_cyc[0], 201);
    check("b2b_rv_cyc1", rv_cyc[1], 406);
    check("b2b_rv_dat0", rv_dat[0], 24'h111111);
    check("b2b_rv_dat1", rv_dat[1], 24'h222222);
    check("b2b_ready_cycle", ready_cyc, 205);
    check("b2b_cs_gap_ok", (min_gap >= D), 1);

    // Offer new data mid-frame; it must be ignored
    start_frame(24'h5A5A5A, 24'h0, 1'b0);
    watch(49);
    tx_data  = 24'hFFFFFF;
    tx_valid = 1'b1;
    watch(1);
    tx_valid = 1'b0;
    tx_data  = '0;
    watch(160);
    check("poke_rv_count", rv_n, 1);
    check("poke_rv_data", rv_dat[0], 24'h5A5A5A);
    check("poke_ready_cycle", ready_cyc, 205);

    // Reset mid-frame aborts cleanly
    start_frame(24'h3C3C3C, 24'h0, 1'b0);
    watch(100);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_cs", spi_cs, 1);
    check("abort_sck", spi_sck, 0);
    check("abort_sdo", spi_sdo, 0);
    check("abort_rx_valid", rx_valid, 0);
    check("abort_ready", tx_ready, 1);
    check("abort_rx_data", rx_data, 0);
    clear_stats();
    watch(250);
    check("abort_no_rv", rv_n, 0);
    start_frame(24'h0F0F0F, 24'h0, 1'b0);
    watch(210);
    check("after_rv_cycle", rv_cyc[0], 201);
    check("after_rv_data", rv_dat[0], 24'h0F0F0F);

    // Small instance: W=8, CLK_DIV=2
    b_rv_n   = 0;
    b_rv_cyc = 0;
    b_rv_dat = '0;
    b_tx_data  = 8'h81;
    b_tx_valid = 1'b1;
    @(posedge clk);
    #1;
    b_tx_valid = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (b_rx_valid) begin
        if (b_rv_n == 0) begin
          b_rv_cyc = c;
          b_rv_dat = b_rx_data;
        end
        b_rv_n++;
      end
    end
    check("small_rv_count", b_rv_n, 1);
    check("small_rv_cycle", b_rv_cyc, 37);
    check("small_rv_data", b_rv_dat, 8'h81);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
